// File: rtl/obj_pkg.sv
// Shared types and constants for the object spawn scheduler.
// Object word layout: [25:23] frame, [22:21] identity, [20:10] hpos, [9:0] vpos.
package obj_pkg;

    localparam int unsigned NUM_SLOTS = 5;
    localparam int unsigned SLOT_W    = 3;
    localparam int unsigned OBJ_W     = 26;

    localparam int unsigned FRAME_LSB = 23;
    localparam int unsigned FRAME_W   = 3;
    localparam int unsigned ID_LSB    = 21;
    localparam int unsigned ID_W      = 2;
    localparam int unsigned HPOS_LSB  = 10;
    localparam int unsigned HPOS_W    = 11;
    localparam int unsigned VPOS_LSB  = 0;
    localparam int unsigned VPOS_W    = 10;

    localparam logic [ID_W-1:0] ID_COLLECT = 2'd0;
    localparam logic [ID_W-1:0] ID_NOTE    = 2'd1;

    typedef enum logic [1:0] {
        StIdle,
        StSelect,
        StOffer,
        StHold
    } spawn_state_e;

    function automatic logic [OBJ_W-1:0] make_obj(
        input logic [ID_W-1:0]   id,
        input logic [HPOS_W-1:0] hpos,
        input logic [VPOS_W-1:0] vpos
    );
        logic [OBJ_W-1:0] w;
        w = '0;
        w[FRAME_LSB +: FRAME_W] = '0;
        w[ID_LSB +: ID_W]       = id;
        w[HPOS_LSB +: HPOS_W]   = hpos;
        w[VPOS_LSB +: VPOS_W]   = vpos;
        return w;
    endfunction

endpackage

// File: rtl/obj_spawn_sched_lfsr16.sv
// 16-bit Galois LFSR (taps 16,14,13,11), free-running, shifts toward bit 0.
module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clock,
    input  logic        reset,
    output logic [15:0] q
);

    always_ff @(posedge clock) begin
        if (reset) begin
            q <= SEED;
        end else begin
            q <= {1'b0, q[15:1]} ^ (q[0] ? 16'hB400 : 16'h0000);
        end
    end

endmodule

// File: rtl/obj_spawn_sched.sv
// Spawn scheduler: merges timer and MIDI spawn requests and offers one object word
// per valid/ack handshake into the lowest free object slot.
module obj_spawn_sched
    import obj_pkg::*;
#(
    parameter int unsigned SCREEN_WIDTH  = 1024,
    parameter int unsigned BASE_INTERVAL = 120,
    parameter int unsigned INTERVAL_STEP = 8,
    parameter int unsigned MIN_INTERVAL  = 30,
    parameter int unsigned VPOS_MIN      = 64,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 vsync_pulse,
    input  logic [3:0]           speed,
    input  logic [NUM_SLOTS-1:0] slot_busy,
    input  logic                 midi_ready,
    input  logic [6:0]           key1_index,
    output logic                 spawn_valid,
    output logic [SLOT_W-1:0]    spawn_slot,
    output logic [OBJ_W-1:0]     spawn_obj,
    input  logic                 spawn_ack,
    output logic [7:0]           drop_count
);

    spawn_state_e state_q, state_d;

    logic [11:0]       timer_q, timer_d;
    logic              timer_pend_q, timer_pend_d;
    logic              midi_pend_q, midi_pend_d;
    logic              served_midi_q, served_midi_d;
    logic [4:0]        key_q, key_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [OBJ_W-1:0]  obj_q, obj_d;
    logic [7:0]        drop_q, drop_d;

    logic [15:0] lfsr_q;
    logic        unused_lfsr;

    lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clock (clock),
        .reset (reset),
        .q     (lfsr_q)
    );

    assign unused_lfsr = ^lfsr_q[15:9];

    logic [11:0] step_total;
    logic [11:0] reload;
    logic        frame_ev, tick, midi_ev;

    assign frame_ev = enable && vsync_pulse;
    assign tick     = frame_ev && (timer_q == 12'd1);
    assign midi_ev  = enable && midi_ready && (key1_index != 7'd0);

    // Reload saturates at the floor when the speed reduction meets or exceeds the base.
    always_comb begin
        step_total = 12'(speed) * 12'(INTERVAL_STEP);
        if (step_total >= 12'(BASE_INTERVAL) ||
            (12'(BASE_INTERVAL) - step_total) < 12'(MIN_INTERVAL)) begin
            reload = 12'(MIN_INTERVAL);
        end else begin
            reload = 12'(BASE_INTERVAL) - step_total;
        end
    end

    logic              free_found;
    logic [SLOT_W-1:0] free_slot;

    always_comb begin
        free_found = 1'b0;
        free_slot  = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!slot_busy[i]) begin
                free_found = 1'b1;
                free_slot  = SLOT_W'(i + 1);
            end
        end
    end

    logic [HPOS_W-1:0] spawn_hpos;
    logic [VPOS_W-1:0] timer_vpos, note_vpos;

    assign spawn_hpos = HPOS_W'(SCREEN_WIDTH - 1);
    assign timer_vpos = VPOS_W'(VPOS_MIN) + {1'b0, lfsr_q[8:0]};
    assign note_vpos  = VPOS_W'(VPOS_MIN) + {1'b0, key_q, 4'b0000};

    logic timer_clr, midi_clr, sel_drop, load_offer;

    always_comb begin
        state_d    = state_q;
        timer_clr  = 1'b0;
        midi_clr   = 1'b0;
        sel_drop   = 1'b0;
        load_offer = 1'b0;

        case (state_q)
            StIdle: begin
                if (timer_pend_q || midi_pend_q) state_d = StSelect;
            end
            StSelect: begin
                if (!timer_pend_q && !midi_pend_q) begin
                    state_d = StIdle;
                end else if (!free_found) begin
                    // Timer spawns are discarded when full; MIDI keeps waiting.
                    timer_clr = 1'b1;
                    sel_drop  = timer_pend_q;
                    state_d   = StIdle;
                end else begin
                    load_offer = 1'b1;
                    state_d    = StOffer;
                end
            end
            StOffer: begin
                if (spawn_ack) begin
                    state_d = StHold;
                    if (served_midi_q) midi_clr = 1'b1;
                    else               timer_clr = 1'b1;
                end
            end
            StHold:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (!enable) begin
            state_d    = StIdle;
            sel_drop   = 1'b0;
            load_offer = 1'b0;
        end
    end

    always_comb begin
        timer_d       = timer_q;
        timer_pend_d  = 1'b0;
        midi_pend_d   = 1'b0;
        key_d         = key_q;
        served_midi_d = served_midi_q;
        slot_d        = slot_q;
        obj_d         = obj_q;
        drop_d        = drop_q;

        if (frame_ev) timer_d = (timer_q == 12'd1) ? reload : timer_q - 12'd1;

        // New requests win over a same-cycle clear so nothing is silently lost.
        if (enable) begin
            timer_pend_d = tick || (timer_pend_q && !timer_clr);
            midi_pend_d  = midi_ev || (midi_pend_q && !midi_clr);
        end

        if (midi_ev) key_d = 5'(key1_index - 7'd48);

        if (load_offer) begin
            served_midi_d = midi_pend_q;
            slot_d        = free_slot;
            obj_d         = midi_pend_q ? make_obj(ID_NOTE, spawn_hpos, note_vpos)
                                        : make_obj(ID_COLLECT, spawn_hpos, timer_vpos);
        end

        if (((tick && timer_pend_q && !timer_clr) || sel_drop) && drop_q != 8'hFF) begin
            drop_d = drop_q + 8'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= StIdle;
            timer_q       <= 12'(BASE_INTERVAL);
            timer_pend_q  <= 1'b0;
            midi_pend_q   <= 1'b0;
            served_midi_q <= 1'b0;
            key_q         <= '0;
            slot_q        <= '0;
            obj_q         <= '0;
            drop_q        <= '0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            timer_pend_q  <= timer_pend_d;
            midi_pend_q   <= midi_pend_d;
            served_midi_q <= served_midi_d;
            key_q         <= key_d;
            slot_q        <= slot_d;
            obj_q         <= obj_d;
            drop_q        <= drop_d;
        end
    end

    assign spawn_valid = (state_q == StOffer);
    assign spawn_slot  = slot_q;
    assign spawn_obj   = obj_q;
    assign drop_count  = drop_q;

endmodule

// File: tb/tb_obj_spawn_sched.sv
// Directed + randomized bench for obj_spawn_sched against a small arithmetic model.
module tb_obj_spawn_sched;

    logic        clock = 1'b0;
    logic        reset, enable, vsync_pulse, midi_ready, spawn_ack;
    logic [3:0]  speed;
    logic [4:0]  slot_busy;
    logic [6:0]  key1_index;
    logic        spawn_valid;
    logic [2:0]  spawn_slot;
    logic [25:0] spawn_obj;
    logic [7:0]  drop_count;

    obj_spawn_sched dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .vsync_pulse (vsync_pulse),
        .speed       (speed),
        .slot_busy   (slot_busy),
        .midi_ready  (midi_ready),
        .key1_index  (key1_index),
        .spawn_valid (spawn_valid),
        .spawn_slot  (spawn_slot),
        .spawn_obj   (spawn_obj),
        .spawn_ack   (spawn_ack),
        .drop_count  (drop_count)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;
    int frames_left = 120;
    bit seen_valid = 1'b0;
    logic [15:0] lfsr_m, lfsr_prev;

    function automatic logic [15:0] lfsr_step(input logic [15:0] x);
        logic [15:0] y;
        y = x >> 1;
        if (x[0]) y = y ^ 16'hB400;
        return y;
    endfunction

    // Model LFSR; lfsr_prev is the value that was live during the previous cycle.
    always @(posedge clock) begin
        lfsr_prev <= lfsr_m;
        lfsr_m    <= reset ? 16'hACE1 : lfsr_step(lfsr_m);
    end

    function automatic int interval(input int s);
        int v;
        v = 120 - s * 8;
        return (v < 30) ? 30 : v;
    endfunction

    function automatic int lowest_free(input logic [4:0] busy);
        for (int i = 0; i < 5; i++) if (!busy[i]) return i + 1;
        return 0;
    endfunction

    function automatic int note_vpos(input int k);
        return 64 + (((k - 48) & 31) * 16);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
        seen_valid |= spawn_valid;
    endtask

    task automatic frame_tick();
        if (enable) frames_left = (frames_left == 1) ? interval(int'(speed)) : frames_left - 1;
    endtask

    task automatic pulse();
        vsync_pulse = 1'b1;
        cyc();
        vsync_pulse = 1'b0;
        frame_tick();
        cyc();
        cyc();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
        frames_left = 120;
    endtask

    task automatic midi(input int k);
        midi_ready = 1'b1;
        key1_index = 7'(k);
        cyc();
        midi_ready = 1'b0;
        key1_index = 7'd0;
    endtask

    task automatic ack();
        spawn_ack = 1'b1;
        cyc();
        spawn_ack = 1'b0;
    endtask

    task automatic wait_valid(input int bound, output int n);
        n = 0;
        while (!spawn_valid && n < bound) begin
            cyc();
            n++;
        end
    endtask

    task automatic check_timer_obj(input string tag, input int slot);
        logic [25:0] o;
        int exp_v;
        o = spawn_obj;
        exp_v = 64 + int'(lfsr_prev[8:0]);
        check({tag, " valid"}, 32'(spawn_valid), 32'd1);
        check({tag, " slot"}, 32'(spawn_slot), 32'(slot));
        check({tag, " frame/id/hpos"}, 32'(o[25:10]), 32'h03FF);
        check({tag, " vpos"}, 32'(o[9:0]), 32'(exp_v));
        check({tag, " vpos range"}, 32'(o[9:0] >= 10'd64 && o[9:0] <= 10'd575), 32'd1);
    endtask

    task automatic check_note_obj(input string tag, input int slot, input int k);
        logic [25:0] o;
        o = spawn_obj;
        check({tag, " valid"}, 32'(spawn_valid), 32'd1);
        check({tag, " slot"}, 32'(spawn_slot), 32'(slot));
        check({tag, " frame/id/hpos"}, 32'(o[25:10]), 32'h0BFF);
        check({tag, " vpos"}, 32'(o[9:0]), 32'(note_vpos(k)));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, s, k;
        logic [4:0] busy;
        logic [25:0] hold_obj;
        logic [2:0]  hold_slot;
        bit stable;

        reset = 1'b1; enable = 1'b0; vsync_pulse = 1'b0; midi_ready = 1'b0;
        spawn_ack = 1'b0; speed = 4'd0; slot_busy = 5'd0; key1_index = 7'd0;
        do_reset();
        check("reset valid", 32'(spawn_valid), 32'd0);
        check("reset slot", 32'(spawn_slot), 32'd0);
        check("reset obj", 32'(spawn_obj), 32'd0);
        check("reset drop", 32'(drop_count), 32'd0);

        // Timer path: first interval is the reset value, then the speed-scaled reload.
        enable = 1'b1;
        speed = 4'd1;
        repeat (119) pulse();
        check("t1 no early spawn", 32'(seen_valid), 32'd0);
        vsync_pulse = 1'b1;
        cyc();
        vsync_pulse = 1'b0;
        frame_tick();
        cyc();
        check("t1 latency N+1", 32'(spawn_valid), 32'd0);
        cyc();
        check_timer_obj("t1 first", 1);
        ack();
        check("t1 valid after ack", 32'(spawn_valid), 32'd0);
        cyc();
        seen_valid = 1'b0;
        repeat (111) pulse();
        check("t1 no spawn before 112", 32'(seen_valid), 32'd0);
        pulse();
        check_timer_obj("t1 reload 112", 1);
        ack();
        cyc();

        for (int it = 0; it < 3; it++) begin
            s = int'($urandom_range(0, 15));
            speed = 4'(s);
            n = 0;
            while (!spawn_valid && n < 200) begin pulse(); n++; end
            ack();
            cyc();
            n = 0;
            while (!spawn_valid && n < 200) begin pulse(); n++; end
            check($sformatf("rand interval speed %0d", s), 32'(n), 32'(interval(s)));
            check_timer_obj("rand timer obj", 1);
            ack();
            cyc();
        end

        // MIDI spawns into the lowest free slot.
        for (int it = 0; it < 5; it++) begin
            if (it == 0) begin k = 60; busy = 5'b00011; end
            else begin k = int'($urandom_range(1, 127)); busy = 5'($urandom_range(0, 30)); end
            slot_busy = busy;
            midi(k);
            cyc();
            check("midi latency N+1", 32'(spawn_valid), 32'd0);
            cyc();
            check_note_obj($sformatf("midi key %0d", k), lowest_free(busy), k);
            ack();
            cyc();
        end
        slot_busy = 5'd0;

        spawn_ack = 1'b1;
        cyc();
        cyc();
        spawn_ack = 1'b0;
        check("stray ack ignored", 32'(spawn_valid), 32'd0);

        // Simultaneous timer tick and MIDI event: MIDI first, timer next.
        while (frames_left != 1) pulse();
        k = int'($urandom_range(1, 127));
        vsync_pulse = 1'b1;
        midi_ready = 1'b1;
        key1_index = 7'(k);
        cyc();
        vsync_pulse = 1'b0;
        midi_ready = 1'b0;
        key1_index = 7'd0;
        frame_tick();
        cyc();
        cyc();
        check_note_obj("t3 midi first", 1, k);
        ack();
        slot_busy = 5'b00001;
        wait_valid(10, n);
        check("t3 second offer latency", 32'(n), 32'd3);
        check_timer_obj("t3 timer second", 2);
        ack();
        cyc();
        slot_busy = 5'd0;

        // All slots full: timer spawn dropped, MIDI held until a slot frees.
        do_reset();
        slot_busy = 5'b11111;
        k = int'($urandom_range(1, 127));
        midi(k);
        seen_valid = 1'b0;
        repeat (120) pulse();
        check("t4 no offer while full", 32'(seen_valid), 32'd0);
        check("t4 drop count", 32'(drop_count), 32'd1);
        slot_busy = 5'b11011;
        wait_valid(3, n);
        check_note_obj("t4 midi retained", 3, k);

        // Offer held stable without ack, then withdrawn by reset.
        hold_obj = spawn_obj;
        hold_slot = spawn_slot;
        stable = 1'b1;
        repeat (50) begin
            cyc();
            if (spawn_valid !== 1'b1 || spawn_obj !== hold_obj || spawn_slot !== hold_slot)
                stable = 1'b0;
        end
        check("t5 offer stable 50 cycles", 32'(stable), 32'd1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        frames_left = 120;
        check("t5 reset valid", 32'(spawn_valid), 32'd0);
        check("t5 reset drop", 32'(drop_count), 32'd0);
        check("t5 reset obj", 32'(spawn_obj), 32'd0);

        // Dropping enable withdraws the offer and discards pending requests.
        slot_busy = 5'd0;
        midi(int'($urandom_range(1, 127)));
        cyc();
        cyc();
        check("enable offer up", 32'(spawn_valid), 32'd1);
        enable = 1'b0;
        cyc();
        check("enable low withdraws", 32'(spawn_valid), 32'd0);
        enable = 1'b1;
        repeat (4) cyc();
        check("enable pend cleared", 32'(spawn_valid), 32'd0);

        // Fastest speed with ack withheld across two expiries.
        do_reset();
        speed = 4'd15;
        repeat (120) pulse();
        check_timer_obj("t6 first expiry", 1);
        repeat (29) pulse();
        check("t6 drop before overrun", 32'(drop_count), 32'd0);
        pulse();
        check("t6 drop after overrun", 32'(drop_count), 32'd1);
        check("t6 offer still valid", 32'(spawn_valid), 32'd1);
        ack();
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
